// File: rtl/axis_packet_rr_scheduler.sv
// Packet-granular round-robin grant controller for one shared AXI-Stream output.
// It drives the select of an external data mux, returns per-input tready and
// produces the merged tvalid. A grant is held from the first beat to tlast,
// and idle inputs are skipped so back-to-back packets leave no bubble.
// Optional feature macro: ARB_WEIGHTED_EN adds the cfg_weight port and a per-turn
// packet quota. Without it every input gets one packet per turn.
module axis_packet_rr_scheduler #(
    parameter int unsigned NUM_INPUTS   = 3,
    parameter int unsigned IDX_WIDTH    = 2,
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  logic                               axis_aclk,
    input  logic                               axis_resetn,
    input  logic [NUM_INPUTS-1:0]              req_tvalid,
    input  logic [NUM_INPUTS-1:0]              req_tlast,
    input  logic                               out_tready,
    output logic [NUM_INPUTS-1:0]              in_tready,
    output logic                               out_tvalid,
    output logic                               grant_valid,
    output logic [NUM_INPUTS-1:0]              grant_onehot,
    output logic [IDX_WIDTH-1:0]               grant_idx
`ifdef ARB_WEIGHTED_EN
    ,
    input  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] cfg_weight
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StXfer
    } state_e;

    state_e               state;
    logic [IDX_WIDTH-1:0] rr_ptr;

    logic                 cur_valid;
    logic                 cur_last;
    logic                 any_valid;
    logic                 beat;
    logic                 eop;
    logic [IDX_WIDTH-1:0] next_g;
    logic [IDX_WIDTH-1:0] pick_ptr;
    logic [IDX_WIDTH-1:0] pick_next;

    logic [WEIGHT_WIDTH-1:0] cnt_inc;
    logic [WEIGHT_WIDTH-1:0] quota;
    logic                    keep_grant;

    // First valid input at or after start, wrapping; start itself has top priority.
    function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_INPUTS-1:0] valid,
                                                     input logic [IDX_WIDTH-1:0]  start);
        logic                 found_hi;
        logic [IDX_WIDTH-1:0] sel_hi;
        logic [IDX_WIDTH-1:0] sel_lo;
        found_hi = 1'b0;
        sel_hi   = start;
        sel_lo   = start;
        // Descending scan so the lowest qualifying index is assigned last.
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (valid[i]) begin
                if (IDX_WIDTH'(i) >= start) begin
                    found_hi = 1'b1;
                    sel_hi   = IDX_WIDTH'(i);
                end else begin
                    sel_lo = IDX_WIDTH'(i);
                end
            end
        end
        return found_hi ? sel_hi : sel_lo;
    endfunction

    function automatic logic [NUM_INPUTS-1:0] to_onehot(input logic [IDX_WIDTH-1:0] idx);
        logic [NUM_INPUTS-1:0] oh;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            oh[i] = (idx == IDX_WIDTH'(i));
        end
        return oh;
    endfunction

    // Handshake decode against the currently granted input.
    assign cur_valid  = |(req_tvalid & grant_onehot);
    assign cur_last   = |(req_tlast & grant_onehot);
    assign any_valid  = |req_tvalid;
    assign out_tvalid = grant_valid & cur_valid;
    assign beat       = out_tvalid & out_tready;
    assign eop        = beat & cur_last;
    assign in_tready  = grant_onehot & {NUM_INPUTS{grant_valid & out_tready}};

    assign next_g    = (grant_idx == IDX_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
    assign pick_ptr  = rr_pick(req_tvalid, rr_ptr);
    assign pick_next = rr_pick(req_tvalid, next_g);

`ifdef ARB_WEIGHTED_EN
    logic [WEIGHT_WIDTH-1:0] pkt_cnt;
    logic [WEIGHT_WIDTH-1:0] weight_sel;

    // Quota of the granted input; a zero weight still earns one packet per turn.
    always_comb begin
        weight_sel = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_onehot[i]) begin
                weight_sel = cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        quota   = (weight_sel == '0) ? WEIGHT_WIDTH'(1) : weight_sel;
        cnt_inc = pkt_cnt + 1'b1;
    end
`else
    assign quota   = WEIGHT_WIDTH'(1);
    assign cnt_inc = WEIGHT_WIDTH'(1);
`endif

    assign keep_grant = (cnt_inc < quota);

    // Grant FSM: all grant outputs and arbitration state are registered here.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state        <= StIdle;
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
            grant_idx    <= '0;
            rr_ptr       <= '0;
`ifdef ARB_WEIGHTED_EN
            pkt_cnt      <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_valid) begin
                        state        <= StHold;
                        grant_valid  <= 1'b1;
                        grant_idx    <= pick_ptr;
                        grant_onehot <= to_onehot(pick_ptr);
`ifdef ARB_WEIGHTED_EN
                        pkt_cnt      <= '0;
`endif
                    end
                end
                StHold, StXfer: begin
                    if (eop) begin
                        state <= StHold;
                        if (keep_grant) begin
`ifdef ARB_WEIGHTED_EN
                            pkt_cnt <= cnt_inc;
`endif
                        end else begin
                            // g is valid on its last beat, so a winner always exists;
                            // it is searched from g+1 with g itself as last candidate.
                            rr_ptr       <= next_g;
                            grant_idx    <= pick_next;
                            grant_onehot <= to_onehot(pick_next);
`ifdef ARB_WEIGHTED_EN
                            pkt_cnt      <= '0;
`endif
                        end
                    end else if (state == StHold) begin
                        if (beat) begin
                            state <= StXfer;
                        end else if (!cur_valid) begin
                            if (any_valid) begin
                                // Forfeit: granted input has nothing at a boundary.
                                grant_idx    <= pick_next;
                                grant_onehot <= to_onehot(pick_next);
`ifdef ARB_WEIGHTED_EN
                                pkt_cnt      <= '0;
`endif
                            end else begin
                                state        <= StIdle;
                                grant_valid  <= 1'b0;
                                grant_onehot <= '0;
                                grant_idx    <= '0;
                                rr_ptr       <= next_g;
                            end
                        end
                    end
                end
                default: begin
                    state        <= StIdle;
                    grant_valid  <= 1'b0;
                    grant_onehot <= '0;
                    grant_idx    <= '0;
                end
            endcase
        end
    end

endmodule
